// File: rtl/countdown_arbiter_if.sv
// ----------------------------------------------------------------------------
// countdown_arbiter_if
//   Bundles the requester-side bus of countdown_arbiter.
//
//   Signals
//     req       requester -> arbiter  per-requester request level
//     load_val  requester -> arbiter  packed load values, requester i at [i*WIDTH +: WIDTH]
//     hold      requester -> arbiter  freeze the count while high
//     grant     arbiter -> requester  one-hot current owner
//     done      arbiter -> requester  one-cycle completion pulse to the owner
//     count     arbiter -> requester  live counter value
//     busy      arbiter -> requester  high while a job is in progress
//
//   Modports
//     master    requester side (drives req/load_val/hold)
//     slave     arbiter side (drives grant/done/count/busy)
// ----------------------------------------------------------------------------
interface countdown_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic                  hold;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      count;
    logic                  busy;

    modport master (
        output req, load_val, hold,
        input  grant, done, count, busy
    );

    modport slave (
        input  req, load_val, hold,
        output grant, done, count, busy
    );
endinterface

// File: rtl/countdown_arbiter.sv
// ----------------------------------------------------------------------------
// countdown_arbiter
//   Shares one WIDTH-bit down counter among NREQ requesters. A round-robin
//   arbiter picks one requester, loads its value, counts it down to zero,
//   pulses done to that owner and then releases the counter.
//
//   Ports
//     clk   system clock, all state changes on posedge
//     rst   synchronous reset, active-high
//     bus   countdown_arbiter_if.slave
//             in : req, load_val, hold
//             out: grant, done, count (registered), busy (decoded from state)
// ----------------------------------------------------------------------------
module countdown_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    countdown_arbiter_if.slave  bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [IDXW-1:0]   owner_q, owner_n;
    logic [IDXW-1:0]   ptr_q,   ptr_n;
    logic [NREQ-1:0]   grant_q, grant_n;
    logic [NREQ-1:0]   done_q,  done_n;
    logic [WIDTH-1:0]  count_q, count_n;

    // Round-robin search: first set req bit after ptr, wrapping modulo NREQ.
    logic              win_found;
    logic [IDXW-1:0]   win_idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDXW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        grant_n = grant_q;
        done_n  = '0;
        count_n = count_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_n = COUNT;
                    owner_n = win_idx;
                    grant_n = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    count_n = bus.load_val[int'(win_idx)*WIDTH +: WIDTH];
                end
            end

            COUNT: begin
                if (!bus.req[owner_q]) begin
                    // Abort: owner withdrew, release without a done pulse.
                    state_n = IDLE;
                    grant_n = '0;
                    count_n = '0;
                    ptr_n   = owner_q;
                end else if (count_q == '0) begin
                    state_n = DONE;
                    done_n  = grant_q;
                end else if (!bus.hold) begin
                    count_n = count_q - WIDTH'(1);
                end
            end

            DONE: begin
                // Arbitration waits for IDLE, giving the one-cycle gap between jobs.
                state_n = IDLE;
                grant_n = '0;
                ptr_n   = owner_q;
            end

            default: begin
                state_n = IDLE;
                grant_n = '0;
                count_n = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IDXW'(NREQ - 1);   // requester 0 wins first after reset
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            count_q <= count_n;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_countdown_arbiter.sv
// ----------------------------------------------------------------------------
// tb_countdown_arbiter
//   Directed tests for countdown_arbiter (NREQ=4, WIDTH=4). Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_countdown_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    countdown_arbiter_if #(.NREQ(4), .WIDTH(4)) bus ();

    countdown_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req      = '0;
        bus.load_val = '0;
        bus.hold     = 1'b0;
        rst          = 1'b1;
        cyc();
        cyc();
        rst          = 1'b0;
    endtask

    // Test 1: reset values, reset mid-COUNT, priority to requester 0 after reset.
    task automatic test_reset();
        do_reset();
        total++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.count !== 4'd0 || bus.busy !== 1'b0)
            $display("FAIL reset_init: grant=%b done=%b count=%0d busy=%b expected 0000 0000 0 0", bus.grant, bus.done, bus.count, bus.busy);
        else passed++;

        bus.req      = 4'b0010;
        bus.load_val = 16'h0050;          // requester 1 loads 5
        cyc();                             // grant, count=5
        cyc();                             // 4
        cyc();                             // 3
        total++; if (bus.grant !== 4'b0010 || bus.count !== 4'd3)
            $display("FAIL reset_pre: grant=%b count=%0d expected 0010 3", bus.grant, bus.count);
        else passed++;

        rst = 1'b1;
        cyc();
        total++; if (bus.done !== 4'b0000)
            $display("FAIL reset_nodone: done=%b expected 0000", bus.done);
        else passed++;
        cyc();
        total++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.count !== 4'd0 || bus.busy !== 1'b0)
            $display("FAIL reset_mid: grant=%b done=%b count=%0d busy=%b expected 0000 0000 0 0", bus.grant, bus.done, bus.count, bus.busy);
        else passed++;

        rst     = 1'b0;
        bus.req = 4'b0011;
        cyc();
        total++; if (bus.grant !== 4'b0001)
            $display("FAIL reset_prio: grant=%b expected 0001", bus.grant);
        else passed++;
    endtask

    // Test 2: single job L=5, count 5..0, done 6 cycles after grant.
    task automatic test_single();
        logic [3:0] exp_count;
        do_reset();
        bus.req      = 4'b0001;
        bus.load_val = 16'h0005;
        for (int c = 0; c <= 5; c++) begin
            cyc();
            exp_count = 4'(5 - c);
            total++; if (bus.grant !== 4'b0001 || bus.count !== exp_count || bus.done !== 4'b0000 || bus.busy !== 1'b1)
                $display("FAIL single_cnt%0d: grant=%b count=%0d done=%b busy=%b expected 0001 %0d 0000 1", c, bus.grant, bus.count, bus.done, bus.busy, exp_count);
            else passed++;
        end
        cyc();                             // 6 cycles after grant rose
        total++; if (bus.done !== 4'b0001 || bus.grant !== 4'b0001 || bus.count !== 4'd0)
            $display("FAIL single_done: done=%b grant=%b count=%0d expected 0001 0001 0", bus.done, bus.grant, bus.count);
        else passed++;
        bus.req = 4'b0000;
        cyc();
        total++; if (bus.done !== 4'b0000 || bus.grant !== 4'b0000 || bus.busy !== 1'b0)
            $display("FAIL single_idle: done=%b grant=%b busy=%b expected 0000 0000 0", bus.done, bus.grant, bus.busy);
        else passed++;
    endtask

    // Test 3: all four requesting with L=1, round-robin order and job spacing.
    task automatic test_round_robin();
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.req      = 4'b1111;
        bus.load_val = 16'h1111;
        for (int j = 0; j < 5; j++) begin
            cyc();
            total++; if (bus.grant !== order[j] || bus.count !== 4'd1)
                $display("FAIL rr_job%0d_grant: grant=%b count=%0d expected %b 1", j, bus.grant, bus.count, order[j]);
            else passed++;
            cyc();
            total++; if (bus.grant !== order[j] || bus.count !== 4'd0 || bus.done !== 4'b0000)
                $display("FAIL rr_job%0d_zero: grant=%b count=%0d done=%b expected %b 0 0000", j, bus.grant, bus.count, bus.done, order[j]);
            else passed++;
            cyc();
            total++; if (bus.grant !== order[j] || bus.done !== order[j])
                $display("FAIL rr_job%0d_done: grant=%b done=%b expected %b %b", j, bus.grant, bus.done, order[j], order[j]);
            else passed++;
            cyc();
            total++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000)
                $display("FAIL rr_job%0d_gap: grant=%b busy=%b done=%b expected 0000 0 0000", j, bus.grant, bus.busy, bus.done);
            else passed++;
        end
        bus.req = 4'b0000;
    endtask

    // Test 4: zero load value.
    task automatic test_zero_load();
        do_reset();
        bus.req      = 4'b0100;
        bus.load_val = 16'h0000;
        cyc();
        total++; if (bus.grant !== 4'b0100 || bus.count !== 4'd0 || bus.done !== 4'b0000)
            $display("FAIL zero_grant: grant=%b count=%0d done=%b expected 0100 0 0000", bus.grant, bus.count, bus.done);
        else passed++;
        cyc();
        total++; if (bus.done !== 4'b0100 || bus.count !== 4'd0)
            $display("FAIL zero_done: done=%b count=%0d expected 0100 0", bus.done, bus.count);
        else passed++;
        bus.req = 4'b0000;
        cyc();
        total++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.done !== 4'b0000)
            $display("FAIL zero_idle: busy=%b grant=%b done=%b expected 0 0000 0000", bus.busy, bus.grant, bus.done);
        else passed++;
    endtask

    // Test 5: hold for 3 cycles at count=2 delays done by 3 cycles (done at grant+8 for L=4).
    task automatic test_hold();
        do_reset();
        bus.req      = 4'b0001;
        bus.load_val = 16'h0004;
        cyc();                             // grant edge, count=4
        cyc();                             // 3
        cyc();                             // 2
        bus.hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            cyc();
            total++; if (bus.count !== 4'd2 || bus.done !== 4'b0000)
                $display("FAIL hold_freeze%0d: count=%0d done=%b expected 2 0000", h, bus.count, bus.done);
            else passed++;
        end
        bus.hold = 1'b0;
        cyc();
        total++; if (bus.count !== 4'd1)
            $display("FAIL hold_resume: count=%0d expected 1", bus.count);
        else passed++;
        cyc();
        total++; if (bus.count !== 4'd0 || bus.done !== 4'b0000)
            $display("FAIL hold_zero: count=%0d done=%b expected 0 0000", bus.count, bus.done);
        else passed++;
        cyc();                             // grant + 8
        total++; if (bus.done !== 4'b0001)
            $display("FAIL hold_done: done=%b expected 0001", bus.done);
        else passed++;
        bus.req = 4'b0000;
        cyc();
        total++; if (bus.done !== 4'b0000 || bus.busy !== 1'b0)
            $display("FAIL hold_idle: done=%b busy=%b expected 0000 0", bus.done, bus.busy);
        else passed++;
    endtask

    // Test 6: owner aborts, waiting requester 3 is served next; load sampled only at grant.
    task automatic test_abort();
        do_reset();
        bus.req      = 4'b1001;
        bus.load_val = 16'h7004;          // requester 3 loads 7, requester 0 loads 4
        cyc();
        total++; if (bus.grant !== 4'b0001 || bus.count !== 4'd4)
            $display("FAIL abort_grant0: grant=%b count=%0d expected 0001 4", bus.grant, bus.count);
        else passed++;
        cyc();
        cyc();
        total++; if (bus.grant !== 4'b0001 || bus.count !== 4'd2)
            $display("FAIL abort_pre: grant=%b count=%0d expected 0001 2", bus.grant, bus.count);
        else passed++;
        bus.req = 4'b1000;
        cyc();
        total++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.count !== 4'd0 || bus.done !== 4'b0000)
            $display("FAIL abort_idle: busy=%b grant=%b count=%0d done=%b expected 0 0000 0 0000", bus.busy, bus.grant, bus.count, bus.done);
        else passed++;
        cyc();
        total++; if (bus.grant !== 4'b1000 || bus.count !== 4'd7 || bus.done !== 4'b0000)
            $display("FAIL abort_grant3: grant=%b count=%0d done=%b expected 1000 7 0000", bus.grant, bus.count, bus.done);
        else passed++;
        bus.load_val = 16'h2004;          // late change must be ignored
        cyc();
        total++; if (bus.count !== 4'd6)
            $display("FAIL abort_lvlatch: count=%0d expected 6", bus.count);
        else passed++;
        bus.req = 4'b0000;
        cyc();
        total++; if (bus.busy !== 1'b0 || bus.done !== 4'b0000)
            $display("FAIL abort_second: busy=%b done=%b expected 0 0000", bus.busy, bus.done);
        else passed++;
    endtask

    initial begin
        bus.req      = '0;
        bus.load_val = '0;
        bus.hold     = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_load();
        test_hold();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
